audio_ram_arbiter: RTL and testbench
====================================

// Module: audio_ram_arbiter
// PURPOSE
//  Shares the single audio DRAM port between two requesters: the record path, which writes
//  filtered samples, and the playback path, which reads samples.
//  Two-way round-robin arbitration with at most one DRAM transaction in flight.
//  Each requester sees a simple req/ack handshake.
//  The block sits between the record/playback sequencers and the DRAM controller port.
// PARAMETERS
//  AW       22   DRAM word address width
//  DW       16   sample/data width
//  RD_TOUT  255  max cycles waiting for ram_valid after read accept (>=1)
// PORTS
//  clock         in   1   system clock (50 MHz)
//  reset         in   1   synchronous, active-high
//  wr_req        in   1   record path requests a write; held until wr_ack
//  wr_addr       in   AW  write address; stable while wr_req
//  wr_data       in   DW  write data; stable while wr_req
//  wr_ack        out  1   one-cycle pulse: write accepted by DRAM
//  rd_req        in   1   playback path requests a read; held until rd_ack
//  rd_addr       in   AW  read address; stable while rd_req
//  rd_data       out  DW  read result; valid when rd_ack, held until next rd_ack
//  rd_ack        out  1   one-cycle pulse: rd_data valid
//  rd_err        out  1   sticky: a read timed out; cleared only by reset
//  ram_addr      out  AW  DRAM address
//  ram_data_in   out  DW  DRAM write data
//  ram_read      out  1   DRAM read strobe
//  ram_write     out  1   DRAM write strobe
//  ram_data_out  in   DW  DRAM read data
//  ram_valid     in   1   DRAM read data valid
//  ram_waitrq    in   1   DRAM stall: hold command while high
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; all outputs 0; rd_data=0; rd_err=0.
//   - last_grant=RD, so the first tie goes to the write requester.
//  States: IDLE, WRITE, READ_CMD, READ_DATA. ram_read/ram_write are decoded from the registered state.
//  IDLE:
//   - eligible requester = req && !ack (this cycle).
//   - One eligible requester -> grant it. Both eligible -> grant the one not equal to last_grant.
//   - On grant, latch addr (and data for a write) into ram_addr/ram_data_in and update last_grant.
//   - Next state: WRITE or READ_CMD.
//   - ram_addr and ram_data_in hold their last values while idle.
//  WRITE:
//   - ram_write=1; hold until a cycle with ram_waitrq=0 (accept).
//   - Then wr_ack=1 in the next cycle; state returns to IDLE in that same cycle.
//  READ_CMD:
//   - ram_read=1; on accept go to READ_DATA and clear the timeout counter.
//   - If ram_valid=1 in the accept cycle: capture ram_data_out, rd_ack next cycle, go to IDLE.
//  READ_DATA:
//   - ram_read=0; the counter increments each cycle.
//   - On ram_valid: rd_data<=ram_data_out; rd_ack next cycle; go to IDLE.
//   - If the counter reaches RD_TOUT with no valid: rd_data<=0, rd_err<=1, rd_ack next cycle, go to IDLE.
//  Latency from req seen in IDLE at cycle t (no stalls):
//   - write: ram_write at t+1, wr_ack at t+2.
//   - read: ram_read at t+1, valid at t+2, rd_ack at t+3.
//  Edge cases:
//   - ram_valid outside READ_CMD/READ_DATA is ignored.
//   - A requester dropping req mid-transaction does not abort it; the ack is still issued.
//   - Reset mid-transaction: state returns to IDLE at that edge and the strobes drop the next cycle.
//     No ack is issued, and a late ram_valid is ignored.
//   - Idle-to-grant is one cycle minimum, so back-to-back alternation gives each requester every other slot.
//  Timeout counter width: $clog2(RD_TOUT+1); saturating, never wraps.
// STRUCTURE
//  Package audio_ram_pkg:
//   - arb_state_t (IDLE/WRITE/READ_CMD/READ_DATA)
//   - grant_t (GR_WR/GR_RD)
//   - AW/DW defaults
//  Sub-module ram_rr_arbiter: 2-way round-robin.
//   - Inputs: eligible pair, last_grant. Outputs: grant valid and grant id (combinational).
//  The top level holds the FSM, address/data registers, timeout counter and ack generation.
// TESTING
//  1. Write only: wr_req=1, wr_addr=5, wr_data=16'h1234, ram_waitrq=0
//     -> ram_write one cycle with addr 5 and data 1234; wr_ack at t+2; no further writes.
//  2. Read with stall: rd_addr=9, ram_waitrq high 3 cycles, ram_valid 2 cycles after accept, data 16'hBEEF
//     -> ram_read held 4 cycles; rd_data=BEEF with rd_ack; rd_err=0.
//  3. Contention: wr_req and rd_req held for 4 transactions
//     -> order W,R,W,R; each ack exactly once per transaction.
//  4. Timeout: RD_TOUT=4, ram_valid never asserted
//     -> rd_ack 5 cycles after accept, rd_data=0, rd_err=1 and stays 1 through later good reads.
//  5. Reset mid-READ_DATA, then ram_valid arrives
//     -> no rd_ack; outputs 0; next wr_req served normally.
//  6. Spurious ram_valid in IDLE and WRITE -> rd_data unchanged; no rd_ack.

Source files
------------

// File: rtl/audio_ram_arbiter_pkg.sv
// Shared types and default widths for the audio DRAM arbiter slice.
package audio_ram_pkg;

  localparam int AW_DEF = 22;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_CMD  = 2'd2,
    READ_DATA = 2'd3
  } arb_state_t;

  typedef enum logic {
    GR_WR = 1'b0,
    GR_RD = 1'b1
  } grant_t;

endpackage

// File: rtl/audio_ram_arbiter_if.sv
// Requester handshakes plus the DRAM command port; i_/o_ prefixes are from the arbiter's view.
interface audio_ram_arbiter_if
  import audio_ram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          i_wr_req;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_ack;

  logic          i_rd_req;
  logic [AW-1:0] i_rd_addr;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_ack;
  logic          o_rd_err;

  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_data_in;
  logic          o_ram_read;
  logic          o_ram_write;
  logic [DW-1:0] i_ram_data_out;
  logic          i_ram_valid;
  logic          i_ram_waitrq;

  modport slave (
    input  i_wr_req, i_wr_addr, i_wr_data,
    input  i_rd_req, i_rd_addr,
    input  i_ram_data_out, i_ram_valid, i_ram_waitrq,
    output o_wr_ack, o_rd_data, o_rd_ack, o_rd_err,
    output o_ram_addr, o_ram_data_in, o_ram_read, o_ram_write
  );

  modport master (
    output i_wr_req, i_wr_addr, i_wr_data,
    output i_rd_req, i_rd_addr,
    output i_ram_data_out, i_ram_valid, i_ram_waitrq,
    input  o_wr_ack, o_rd_data, o_rd_ack, o_rd_err,
    input  o_ram_addr, o_ram_data_in, o_ram_read, o_ram_write
  );

endinterface

// File: rtl/audio_ram_arbiter_rr.sv
// Two-way round-robin pick: a lone eligible requester wins, a tie goes to the one not granted last.
module ram_rr_arbiter
  import audio_ram_pkg::*;
(
  input  logic   i_wr_elig,
  input  logic   i_rd_elig,
  input  grant_t i_last_grant,
  output logic   o_grant_valid,
  output grant_t o_grant_id
);

  always_comb begin
    // NOTE: every output gets a value before any branch, so no path can infer a latch.
    o_grant_valid = i_wr_elig | i_rd_elig;
    o_grant_id    = GR_WR;
    if (i_wr_elig && i_rd_elig) begin
      if (i_last_grant == GR_WR) o_grant_id = GR_RD;
    end else if (i_rd_elig) begin
      o_grant_id = GR_RD;
    end
  end

endmodule

// File: rtl/audio_ram_arbiter.sv
// Shares one audio DRAM port between the record (write) and playback (read) paths,
// one transaction in flight, with a saturating read-data timeout.
module audio_ram_arbiter
  import audio_ram_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int RD_TOUT = 255
) (
  input logic                clock,
  input logic                reset,
  audio_ram_arbiter_if.slave bus
);

  localparam int            CW        = $clog2(RD_TOUT + 1);
  localparam logic [CW-1:0] TOUT_LAST = CW'(RD_TOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(RD_TOUT);

  arb_state_t    r_state;
  grant_t        r_last_grant;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_data_in;
  logic [DW-1:0] r_rd_data;
  logic          r_wr_ack;
  logic          r_rd_ack;
  logic          r_rd_err;

  logic   w_wr_elig;
  logic   w_rd_elig;
  logic   w_grant_valid;
  grant_t w_grant_id;

  // A requester still holding req during its own ack cycle is not asking again.
  assign w_wr_elig = bus.i_wr_req & ~r_wr_ack;
  assign w_rd_elig = bus.i_rd_req & ~r_rd_ack;

  ram_rr_arbiter u_rr (
    .i_wr_elig     (w_wr_elig),
    .i_rd_elig     (w_rd_elig),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    if (reset) begin
      r_state       <= IDLE;
      r_last_grant  <= GR_RD;
      r_cnt         <= '0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_rd_data     <= '0;
      r_wr_ack      <= 1'b0;
      r_rd_ack      <= 1'b0;
      r_rd_err      <= 1'b0;
    end else begin
      r_wr_ack <= 1'b0;
      r_rd_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_last_grant <= w_grant_id;
            if (w_grant_id == GR_WR) begin
              r_ram_addr    <= bus.i_wr_addr;
              r_ram_data_in <= bus.i_wr_data;
              r_state       <= WRITE;
            end else begin
              r_ram_addr <= bus.i_rd_addr;
              r_state    <= READ_CMD;
            end
          end
        end
        WRITE: begin
          if (!bus.i_ram_waitrq) begin
            r_wr_ack <= 1'b1;
            r_state  <= IDLE;
          end
        end
        READ_CMD: begin
          if (!bus.i_ram_waitrq) begin
            r_cnt <= '0;
            if (bus.i_ram_valid) begin
              r_rd_data <= bus.i_ram_data_out;
              r_rd_ack  <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_state <= READ_DATA;
            end
          end
        end
        READ_DATA: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (bus.i_ram_valid) begin
            r_rd_data <= bus.i_ram_data_out;
            r_rd_ack  <= 1'b1;
            r_state   <= IDLE;
          end else if (r_cnt == TOUT_LAST) begin
            // RD_TOUT cycles waited with no data: return zero and flag it for good.
            r_rd_data <= '0;
            r_rd_err  <= 1'b1;
            r_rd_ack  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_ram_write   = (r_state == WRITE);
  assign bus.o_ram_read    = (r_state == READ_CMD);
  assign bus.o_ram_addr    = r_ram_addr;
  assign bus.o_ram_data_in = r_ram_data_in;
  assign bus.o_wr_ack      = r_wr_ack;
  assign bus.o_rd_ack      = r_rd_ack;
  assign bus.o_rd_data     = r_rd_data;
  assign bus.o_rd_err      = r_rd_err;

endmodule

// File: tb/tb_audio_ram_arbiter.sv
// Scoreboard bench for audio_ram_arbiter: directed scenarios plus a randomized transaction run
// against a transaction-level memory/ack model.
module tb_audio_ram_arbiter;
  import audio_ram_pkg::*;

  localparam int AW      = 22;
  localparam int DW      = 16;
  localparam int RD_TOUT = 4;

  logic clock;
  logic reset;
  int   cyc;

  audio_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  audio_ram_arbiter #(.AW(AW), .DW(DW), .RD_TOUT(RD_TOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, required completion before it");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: memory contents, sticky error, last read value.
  typedef struct {
    bit            is_rd;
    logic [DW-1:0] data;
    bit            err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [int];
  bit            ref_err;
  logic [DW-1:0] ref_last_rd;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [DW-1:0] ref_lookup(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    ref_mem[int'(a)] = d;
    e.is_rd = 1'b0; e.data = '0; e.err = ref_err;
    exp_q.push_back(e);
  endtask

  task automatic expect_rd(input logic [AW-1:0] a, input bit times_out);
    exp_t e;
    if (times_out) ref_err = 1'b1;
    e.is_rd = 1'b1;
    e.data  = times_out ? '0 : ref_lookup(a);
    e.err   = ref_err;
    ref_last_rd = e.data;
    exp_q.push_back(e);
  endtask

  function automatic int lat_wr(input int stall);
    return 2 + stall;
  endfunction

  function automatic int lat_rd(input int stall, input int vd);
    return 2 + stall + ((vd < 0) ? RD_TOUT : vd);
  endfunction

  // DRAM model knobs (written by stimulus) and observations (written by the model).
  int            stall_cfg = 0;
  int            vd_cfg = 1;
  int            spur_until = 0;
  logic [DW-1:0] mem_dram [int];
  int            wr_accepts = 0;
  int            wr_strobes = 0;
  int            rd_strobes = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0;

  initial begin
    int            stall_left;
    int            vcount;
    bit            busy;
    bit            prev;
    logic [DW-1:0] hold;
    stall_left = 0; vcount = 0; prev = 1'b0; hold = '0;
    bus.i_ram_waitrq   = 1'b0;
    bus.i_ram_valid    = 1'b0;
    bus.i_ram_data_out = '0;
    forever begin
      @(posedge clock);
      #2;
      bus.i_ram_valid = 1'b0;
      if (vcount > 0) begin
        vcount--;
        if (vcount == 0) begin
          bus.i_ram_valid    = 1'b1;
          bus.i_ram_data_out = hold;
        end
      end
      if (cyc < spur_until) begin
        bus.i_ram_valid    = 1'b1;
        bus.i_ram_data_out = 16'hDEAD;
      end
      if (bus.o_ram_write) wr_strobes++;
      if (bus.o_ram_read)  rd_strobes++;
      busy = bus.o_ram_read || bus.o_ram_write;
      if (busy && !prev) stall_left = stall_cfg;
      prev = busy;
      if (busy && stall_left > 0) begin
        bus.i_ram_waitrq = 1'b1;
        stall_left--;
      end else begin
        bus.i_ram_waitrq = 1'b0;
        if (bus.o_ram_write) begin
          mem_dram[int'(bus.o_ram_addr)] = bus.o_ram_data_in;
          last_wr_addr = bus.o_ram_addr;
          last_wr_data = bus.o_ram_data_in;
          wr_accepts++;
        end
        if (bus.o_ram_read) begin
          hold = mem_dram.exists(int'(bus.o_ram_addr)) ? mem_dram[int'(bus.o_ram_addr)]
                                                       : dflt(bus.o_ram_addr);
          if (vd_cfg == 0) begin
            bus.i_ram_valid    = 1'b1;
            bus.i_ram_data_out = hold;
          end else if (vd_cfg > 0) begin
            vcount = vd_cfg;
          end
        end
      end
    end
  end

  // Monitor: every ack pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.o_wr_ack || bus.o_rd_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {30'd0, bus.o_wr_ack, bus.o_rd_ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_is_rd", bus.o_rd_ack, e.is_rd);
          check("ack_is_wr", bus.o_wr_ack, !e.is_rd);
          if (e.is_rd) begin
            check("rd_data", bus.o_rd_data, e.data);
            check("rd_err", bus.o_rd_err, e.err);
          end
        end
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
    int start;
    bit got;
    bus.i_wr_addr = a;
    bus.i_wr_data = d;
    bus.i_wr_req  = 1'b1;
    start = cyc;
    got   = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clock);
      if (bus.o_wr_ack) got = 1'b1;
    end
    lat = got ? (cyc - start) : -1;
    @(posedge clock);
    #1;
    bus.i_wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int lat);
    int start;
    bit got;
    bus.i_rd_addr = a;
    bus.i_rd_req  = 1'b1;
    start = cyc;
    got   = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clock);
      if (bus.o_rd_ack) got = 1'b1;
    end
    lat = got ? (cyc - start) : -1;
    @(posedge clock);
    #1;
    bus.i_rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
    ref_err     = 1'b0;
    ref_last_rd = '0;
  endtask

  initial begin
    int lat, lat2, w0, s0, r0;
    bus.i_wr_req = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_rd_req = 1'b0; bus.i_rd_addr = '0;
    ref_err = 1'b0; ref_last_rd = '0;
    reset = 1'b1;
    idle(3);

    check("rst_wr_ack", bus.o_wr_ack, 1'b0);
    check("rst_rd_ack", bus.o_rd_ack, 1'b0);
    check("rst_rd_data", bus.o_rd_data, 16'h0);
    check("rst_rd_err", bus.o_rd_err, 1'b0);
    check("rst_strobes", {bus.o_ram_read, bus.o_ram_write}, 2'b00);
    check("rst_ram_addr", bus.o_ram_addr, 22'h0);
    reset = 1'b0;
    idle(1);

    ref_mem[9] = 16'hBEEF;
    mem_dram[9] = 16'hBEEF;

    // Single write, no stall.
    stall_cfg = 0;
    w0 = wr_accepts; s0 = wr_strobes;
    expect_wr(22'd5, 16'h1234);
    do_write(22'd5, 16'h1234, lat);
    check("wr_latency", lat, lat_wr(0));
    idle(4);
    check("wr_accept_count", wr_accepts - w0, 1);
    check("wr_strobe_cycles", wr_strobes - s0, 1);
    check("wr_addr_seen", last_wr_addr, 22'd5);
    check("wr_data_seen", last_wr_data, 16'h1234);

    // Read with command stall and delayed data.
    stall_cfg = 3; vd_cfg = 2;
    r0 = rd_strobes;
    expect_rd(22'd9, 1'b0);
    do_read(22'd9, lat);
    check("rd_stall_latency", lat, lat_rd(3, 2));
    check("rd_strobe_cycles", rd_strobes - r0, 4);
    check("rd_err_clear", bus.o_rd_err, 1'b0);

    // Contention from reset: both held, round-robin alternates starting with the write.
    apply_reset(2);
    stall_cfg = 0; vd_cfg = 1;
    expect_wr(22'd100, 16'hA001);
    expect_rd(22'd9, 1'b0);
    expect_wr(22'd101, 16'hA002);
    expect_rd(22'd5, 1'b0);
    fork
      begin
        do_write(22'd100, 16'hA001, lat);
        do_write(22'd101, 16'hA002, lat);
      end
      begin
        do_read(22'd9, lat2);
        do_read(22'd5, lat2);
      end
    join
    idle(3);
    check("contention_drained", exp_q.size(), 0);

    // Timeout, then the error stays set through a good read.
    stall_cfg = 0; vd_cfg = -1;
    expect_rd(22'd9, 1'b1);
    do_read(22'd9, lat);
    check("tout_latency", lat, lat_rd(0, -1));
    vd_cfg = 1;
    expect_rd(22'd101, 1'b0);
    do_read(22'd101, lat);
    check("good_after_tout_latency", lat, lat_rd(0, 1));
    check("rd_err_sticky", bus.o_rd_err, 1'b1);

    // Reset while waiting for read data; the late valid must be ignored.
    stall_cfg = 0; vd_cfg = 3;
    bus.i_rd_addr = 22'd3;
    bus.i_rd_req  = 1'b1;
    idle(1);
    check("rst_mid_read_cmd", bus.o_ram_read, 1'b1);
    idle(1);
    reset = 1'b1;
    bus.i_rd_req = 1'b0;
    idle(1);
    reset = 1'b0;
    ref_err = 1'b0; ref_last_rd = '0;
    check("rst_mid_strobes", {bus.o_ram_read, bus.o_ram_write}, 2'b00);
    check("rst_mid_rd_data", bus.o_rd_data, 16'h0);
    check("rst_mid_rd_err", bus.o_rd_err, 1'b0);
    check("rst_mid_ram_addr", bus.o_ram_addr, 22'h0);
    idle(6);
    check("rst_mid_no_ack_rd_data", bus.o_rd_data, 16'h0);
    vd_cfg = 1;
    expect_wr(22'd77, 16'h5A5A);
    do_write(22'd77, 16'h5A5A, lat);
    check("wr_after_rst_latency", lat, lat_wr(0));
    expect_rd(22'd77, 1'b0);
    do_read(22'd77, lat);
    check("rd_after_rst_latency", lat, lat_rd(0, 1));

    // Spurious ram_valid in IDLE, then across a stalled WRITE.
    spur_until = cyc + 2;
    idle(4);
    check("spur_idle_rd_data", bus.o_rd_data, ref_last_rd);
    stall_cfg = 2;
    spur_until = cyc + 3;
    expect_wr(22'd78, 16'h0F0F);
    do_write(22'd78, 16'h0F0F, lat);
    check("spur_wr_latency", lat, lat_wr(2));
    idle(2);
    check("spur_wr_rd_data", bus.o_rd_data, ref_last_rd);

    // Randomized sequential transactions.
    for (int n = 0; n < 40; n++) begin
      bit            is_rd;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            st;
      int            vd;
      is_rd = 1'($urandom_range(1, 0));
      a     = AW'($urandom_range(7, 0));
      d     = DW'($urandom);
      st    = $urandom_range(2, 0);
      vd    = ($urandom_range(7, 0) == 0) ? -1 : $urandom_range(3, 0);
      stall_cfg = st;
      vd_cfg    = vd;
      if (is_rd) begin
        expect_rd(a, vd < 0);
        do_read(a, lat);
        check("rand_rd_latency", lat, lat_rd(st, vd));
      end else begin
        expect_wr(a, d);
        do_write(a, d, lat);
        check("rand_wr_latency", lat, lat_wr(st));
      end
      idle($urandom_range(2, 0));
    end

    idle(8);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
